// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: brightness sequencer feeding the PWM accumulator addend.
// A debounced front-panel button and a host "set level" request both start a
// ramp toward a target level; the level then holds and, for button-started
// sequences, decays back to zero. All level movement happens on a divided tick.
module led_fade_sequencer #(
   parameter int TICK_DIV   = 20,
   parameter int STEP       = 1,
   parameter int HOLD_TICKS = 64
) (
   input  logic       clk_50mhz,
   input  logic       rst,
   input  logic       button,
   input  logic       set_valid,
   input  logic [6:0] set_level,
   output logic       set_ready,
   output logic [6:0] level,
   output logic [1:0] state,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      HOLD  = 2'd2,
      DECAY = 2'd3
   } state_t;

   localparam logic [TICK_DIV-1:0] TICK_ONE  = {{(TICK_DIV-1){1'b0}}, 1'b1};
   localparam logic [7:0]          STEP_W    = 8'(STEP);
   localparam logic [6:0]          STEP_7    = 7'(STEP);
   localparam logic [7:0]          HOLD_LAST = 8'(HOLD_TICKS - 1);

   logic [TICK_DIV-1:0] tick_cnt_q, tick_cnt_d;
   logic                tick;

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic sample_q, sample_d;
   logic deb_q, deb_d;
   logic deb_dly_q, deb_dly_d;
   logic press_q, press_d;

   state_t     state_q, state_d;
   logic [6:0] level_q, level_d;
   logic [6:0] target_q, target_d;
   logic       sticky_q, sticky_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       busy_q, busy_d;

   logic [7:0] level_ext, target_ext;
   logic [7:0] up_gap, down_gap;
   logic [6:0] up_amt, down_amt, decay_amt;

   assign tick      = &tick_cnt_q;
   assign set_ready = (state_q != RAMP) && !press_q;
   assign level     = level_q;
   assign state     = state_q;
   assign busy      = busy_q;

   // Tick divider, button synchronizer, tick-rate debounce and press edge detect
   always_comb begin
      tick_cnt_d = tick_cnt_q + TICK_ONE;
      sync1_d    = button;
      sync2_d    = sync1_q;
      sample_d   = sample_q;
      deb_d      = deb_q;
      if (tick) begin
         sample_d = sync2_q;
         if (sync2_q == sample_q) begin
            deb_d = sync2_q;
         end
      end
      deb_dly_d = deb_q;
      press_d   = deb_dly_q & ~deb_q;
   end

   // Clamped step amounts; 8-bit gaps keep the level from overshooting or wrapping
   always_comb begin
      level_ext  = {1'b0, level_q};
      target_ext = {1'b0, target_q};
      up_gap     = target_ext - level_ext;
      down_gap   = level_ext - target_ext;
      up_amt     = (up_gap < STEP_W) ? up_gap[6:0] : STEP_7;
      down_amt   = (down_gap < STEP_W) ? down_gap[6:0] : STEP_7;
      decay_amt  = (level_ext < STEP_W) ? level_q : STEP_7;
   end

   // Sequencer: press beats host transfer, either beats the tick-driven phase logic
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      target_d   = target_q;
      sticky_d   = sticky_q;
      hold_cnt_d = hold_cnt_q;
      if (press_q) begin
         target_d   = 7'd127;
         sticky_d   = 1'b0;
         state_d    = RAMP;
         hold_cnt_d = 8'd0;
      end else if (set_valid && set_ready) begin
         target_d = set_level;
         sticky_d = 1'b1;
         state_d  = RAMP;
      end else if (tick) begin
         case (state_q)
            RAMP: begin
               if (level_q == target_q) begin
                  state_d    = HOLD;
                  hold_cnt_d = 8'd0;
               end else if (level_q < target_q) begin
                  level_d = level_q + up_amt;
               end else begin
                  level_d = level_q - down_amt;
               end
            end
            HOLD: begin
               if (!sticky_q) begin
                  if (hold_cnt_q == HOLD_LAST) begin
                     state_d = DECAY;
                  end else begin
                     hold_cnt_d = hold_cnt_q + 8'd1;
                  end
               end
            end
            DECAY: begin
               if (level_q == 7'd0) begin
                  state_d = IDLE;
               end else begin
                  level_d = level_q - decay_amt;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // All state registers; reset restores released button and an idle, dark LED
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         tick_cnt_q <= '0;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         sample_q   <= 1'b1;
         deb_q      <= 1'b1;
         deb_dly_q  <= 1'b1;
         press_q    <= 1'b0;
         state_q    <= IDLE;
         level_q    <= 7'd0;
         target_q   <= 7'd0;
         sticky_q   <= 1'b0;
         hold_cnt_q <= 8'd0;
         busy_q     <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         sample_q   <= sample_d;
         deb_q      <= deb_d;
         deb_dly_q  <= deb_dly_d;
         press_q    <= press_d;
         state_q    <= state_d;
         level_q    <= level_d;
         target_q   <= target_d;
         sticky_q   <= sticky_d;
         hold_cnt_q <= hold_cnt_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// tb_led_fade_sequencer: randomized bench for led_fade_sequencer with a
// behavioural model that tracks phase, level, target and button timing.
module tb_led_fade_sequencer;

   localparam int TICK_DIV   = 2;
   localparam int STEP       = 8;
   localparam int HOLD_TICKS = 4;
   localparam int TICK_LEN   = 1 << TICK_DIV;

   logic       clk_50mhz;
   logic       rst;
   logic       button;
   logic       set_valid;
   logic [6:0] set_level;
   logic       set_ready;
   logic [6:0] level;
   logic [1:0] state;
   logic       busy;

   int checkCount;
   int failCount;

   // Behavioural model state
   bit modelKnown;
   int modelPhase;
   int modelLevel;
   int modelTarget;
   bit modelSticky;
   int modelHoldLeft;
   int modelClk;
   bit modelBtnPrev1;
   bit modelBtnPrev2;
   bit modelLastSample;
   bit modelDebounced;
   int fallEdge;
   int edgeIdx;
   bit modelXfer;

   bit       hostPending;
   bit [6:0] hostLevel;

   led_fade_sequencer #(
      .TICK_DIV  (TICK_DIV),
      .STEP      (STEP),
      .HOLD_TICKS(HOLD_TICKS)
   ) dut (
      .clk_50mhz(clk_50mhz),
      .rst      (rst),
      .button   (button),
      .set_valid(set_valid),
      .set_level(set_level),
      .set_ready(set_ready),
      .level    (level),
      .state    (state),
      .busy     (busy)
   );

   // 50 MHz-style free-running clock
   initial clk_50mhz = 1'b0;
   always #5 clk_50mhz = ~clk_50mhz;

   function automatic int minInt(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic bit modelPress();
      return (edgeIdx == fallEdge + 2);
   endfunction

   function automatic bit modelReady();
      return (modelPhase != 1) && !modelPress();
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d t=%0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the model across one clock edge with the inputs seen at that edge
   task automatic modelStep(input bit rstIn, input bit btnIn, input bit svIn, input bit [6:0] slIn);
      bit press;
      bit ready;
      bit tick;
      bit syncVal;
      modelXfer = 1'b0;
      if (rstIn) begin
         modelKnown      = 1'b1;
         modelPhase      = 0;
         modelLevel      = 0;
         modelTarget     = 0;
         modelSticky     = 1'b0;
         modelHoldLeft   = 0;
         modelClk        = 0;
         modelBtnPrev1   = 1'b1;
         modelBtnPrev2   = 1'b1;
         modelLastSample = 1'b1;
         modelDebounced  = 1'b1;
         fallEdge        = -100;
      end else begin
         press   = modelPress();
         ready   = modelReady();
         tick    = (modelClk == TICK_LEN - 1);
         syncVal = modelBtnPrev2;
         if (press) begin
            modelTarget = 127;
            modelSticky = 1'b0;
            modelPhase  = 1;
         end else if (svIn && ready) begin
            modelTarget = int'(slIn);
            modelSticky = 1'b1;
            modelPhase  = 1;
            modelXfer   = 1'b1;
         end else if (tick) begin
            case (modelPhase)
               1: begin
                  if (modelLevel == modelTarget) begin
                     modelPhase    = 2;
                     modelHoldLeft = HOLD_TICKS;
                  end else if (modelLevel < modelTarget) begin
                     modelLevel += minInt(STEP, modelTarget - modelLevel);
                  end else begin
                     modelLevel -= minInt(STEP, modelLevel - modelTarget);
                  end
               end
               2: begin
                  if (!modelSticky) begin
                     modelHoldLeft--;
                     if (modelHoldLeft == 0) modelPhase = 3;
                  end
               end
               3: begin
                  if (modelLevel == 0) modelPhase = 0;
                  else modelLevel -= minInt(STEP, modelLevel);
               end
               default: ;
            endcase
         end
         if (tick) begin
            if (syncVal == modelLastSample && syncVal != modelDebounced) begin
               if (modelDebounced && !syncVal) fallEdge = edgeIdx;
               modelDebounced = syncVal;
            end
            modelLastSample = syncVal;
         end
         modelClk      = (modelClk + 1) % TICK_LEN;
         modelBtnPrev2 = modelBtnPrev1;
         modelBtnPrev1 = btnIn;
      end
      edgeIdx++;
   endtask

   // One clock: drive at the falling edge, check before and after the rising edge
   task automatic applyStimulus(input bit rstIn, input bit btnIn, input bit svIn, input bit [6:0] slIn);
      @(negedge clk_50mhz);
      rst       = rstIn;
      button    = btnIn;
      set_valid = svIn;
      set_level = slIn;
      #1;
      if (modelKnown) checkOutput("set_ready", {31'd0, set_ready}, {31'd0, modelReady()});
      @(posedge clk_50mhz);
      modelStep(rstIn, btnIn, svIn, slIn);
      #1;
      if (modelKnown) begin
         checkOutput("level", {25'd0, level}, modelLevel);
         checkOutput("state", {30'd0, state}, modelPhase);
         checkOutput("busy", {31'd0, busy}, {31'd0, modelPhase != 0});
      end
   endtask

   task automatic runCycles(input int n, input bit btnIn);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, btnIn, hostPending, hostLevel);
         if (modelXfer) hostPending = 1'b0;
      end
   endtask

   task automatic newHostRequest(input bit [6:0] lvl);
      if (!hostPending) begin
         hostLevel   = lvl;
         hostPending = 1'b1;
      end
   endtask

   initial begin
      checkCount  = 0;
      failCount   = 0;
      modelKnown  = 1'b0;
      edgeIdx     = 0;
      fallEdge    = -100;
      hostPending = 1'b0;
      hostLevel   = 7'd0;
      rst         = 1'b1;
      button      = 1'b1;
      set_valid   = 1'b0;
      set_level   = 7'd0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 7'd0);
      checkOutput("reset_level", {25'd0, level}, 0);
      checkOutput("reset_state", {30'd0, state}, 0);
      checkOutput("reset_busy", {31'd0, busy}, 0);
      checkOutput("reset_ready", {31'd0, set_ready}, 1);

      // Single-cycle button glitch must not start a sequence
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
      runCycles(12, 1'b1);
      checkOutput("glitch_state", {30'd0, state}, 0);

      // Host set to 64: ramp then sticky hold for 200 ticks
      newHostRequest(7'd64);
      runCycles(60, 1'b1);
      checkOutput("host64_level", {25'd0, level}, 64);
      checkOutput("host64_state", {30'd0, state}, 2);
      runCycles(200 * TICK_LEN, 1'b1);
      checkOutput("host64_sticky", {30'd0, state}, 2);

      // Button held 10 ticks: ramp to 127, hold, decay back to idle
      runCycles(10 * TICK_LEN, 1'b0);
      runCycles(200, 1'b1);
      checkOutput("press_idle_state", {30'd0, state}, 0);
      checkOutput("press_idle_level", {25'd0, level}, 0);
      checkOutput("press_idle_busy", {31'd0, busy}, 0);

      // Randomized mix of requests, presses, glitches and resets
      for (int iter = 0; iter < 60; iter++) begin
         case ($urandom_range(0, 5))
            0: begin
               newHostRequest(7'($urandom_range(0, 127)));
               runCycles($urandom_range(20, 200), 1'b1);
            end
            1: begin
               runCycles(TICK_LEN * $urandom_range(3, 12), 1'b0);
               runCycles($urandom_range(50, 250), 1'b1);
            end
            2: begin
               newHostRequest(7'($urandom_range(0, 127)));
               runCycles(TICK_LEN * $urandom_range(3, 12), 1'b0);
               runCycles($urandom_range(50, 250), 1'b1);
            end
            3: begin
               runCycles($urandom_range(1, 6), 1'b0);
               runCycles($urandom_range(5, 40), 1'b1);
            end
            4: begin
               hostPending = 1'b0;
               for (int r = 0; r < $urandom_range(1, 3); r++) applyStimulus(1'b1, 1'b1, 1'b0, hostLevel);
            end
            default: begin
               runCycles($urandom_range(10, 100), 1'b1);
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
